// File: rtl/prog_loader.sv
// Streams 12-bit instruction words into program memory until a terminator or overflow.
// Latency: one registered cycle from an accepted word to its pmem write strobe; in_ready is high only in LOAD.
module prog_loader #(
    parameter int          MAX_WORDS = 256,
    parameter logic [11:0] TERM_WORD = 12'h000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic        in_valid,
    input  logic [11:0] in_data,
    output logic        in_ready,
    output logic        pmem_le,
    output logic [7:0]  pmem_laddr,
    output logic [11:0] pmem_ldata,
    output logic        load_done,
    output logic        core_hold,
    output logic        error,
    output logic [8:0]  word_count,
    output logic [11:0] checksum
);

    typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;

    localparam logic [7:0] LAST_ADDR = 8'(MAX_WORDS - 1);

    state_t     state;
    logic [7:0] addr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            addr       <= '0;
            in_ready   <= 1'b0;
            pmem_le    <= 1'b0;
            pmem_laddr <= '0;
            pmem_ldata <= '0;
            load_done  <= 1'b0;
            core_hold  <= 1'b1;
            error      <= 1'b0;
            word_count <= '0;
            checksum   <= '0;
        end else begin
            pmem_le <= 1'b0;
            case (state)
                LOAD: begin
                    // abort beats both start and a coincident transfer
                    if (abort) begin
                        state    <= IDLE;
                        in_ready <= 1'b0;
                    end else if (in_valid) begin
                        pmem_le    <= 1'b1;
                        pmem_laddr <= addr;
                        pmem_ldata <= in_data;
                        word_count <= word_count + 9'd1;
                        checksum   <= checksum ^ in_data;
                        if (in_data == TERM_WORD) begin
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            load_done <= 1'b1;
                            core_hold <= 1'b0;
                        end else if (addr == LAST_ADDR) begin
                            // address parks at the last slot rather than wrapping
                            state    <= ERR;
                            in_ready <= 1'b0;
                            error    <= 1'b1;
                        end else begin
                            addr <= addr + 8'd1;
                        end
                    end
                end
                default: begin
                    if (start) begin
                        state      <= LOAD;
                        addr       <= '0;
                        word_count <= '0;
                        checksum   <= '0;
                        in_ready   <= 1'b1;
                        load_done  <= 1'b0;
                        error      <= 1'b0;
                        core_hold  <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader with a 4-word memory: transaction-level model plus directed scenarios.
module tb_prog_loader;

    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort, in_valid;
    logic [11:0] in_data;
    logic        in_ready, pmem_le, load_done, core_hold, error;
    logic [7:0]  pmem_laddr;
    logic [11:0] pmem_ldata, checksum;
    logic [8:0]  word_count;

    int checks   = 0;
    int failures = 0;
    int cyc_no   = 0;

    prog_loader #(.MAX_WORDS(MAXW), .TERM_WORD(12'h000)) dut (
        .clk(clk), .reset(rst_n), .start(start), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .pmem_le(pmem_le), .pmem_laddr(pmem_laddr), .pmem_ldata(pmem_ldata),
        .load_done(load_done), .core_hold(core_hold), .error(error),
        .word_count(word_count), .checksum(checksum)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_no <= cyc_no + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Model: what the loader must look like, tracked as a load session.
    typedef enum {M_IDLE, M_LOAD, M_DONE, M_ERR} mode_t;
    mode_t       m_mode  = M_IDLE;
    int          m_addr  = 0;
    int          m_cnt   = 0;
    logic [11:0] m_cs    = '0;
    logic        m_le    = 1'b0;
    int          m_laddr = 0;
    logic [11:0] m_ldata = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode <= M_IDLE; m_addr <= 0; m_cnt <= 0; m_cs <= '0;
            m_le <= 1'b0; m_laddr <= 0; m_ldata <= '0;
        end else begin
            m_le <= 1'b0;
            if (m_mode == M_LOAD) begin
                if (abort) m_mode <= M_IDLE;
                else if (in_valid) begin
                    m_le    <= 1'b1;
                    m_laddr <= m_addr;
                    m_ldata <= in_data;
                    m_cnt   <= m_cnt + 1;
                    m_cs    <= m_cs ^ in_data;
                    if (in_data == 12'h000)      m_mode <= M_DONE;
                    else if (m_addr == MAXW - 1) m_mode <= M_ERR;
                    else                         m_addr <= m_addr + 1;
                end
            end else if (start) begin
                m_mode <= M_LOAD; m_addr <= 0; m_cnt <= 0; m_cs <= '0;
            end
        end
    end

    logic [45:0] dut_vec, exp_vec;
    assign dut_vec = {in_ready, pmem_le, pmem_laddr, pmem_ldata, load_done,
                      core_hold, error, word_count, checksum};
    assign exp_vec = {m_mode == M_LOAD, m_le, 8'(m_laddr), m_ldata, m_mode == M_DONE,
                      m_mode != M_DONE, m_mode == M_ERR, 9'(m_cnt), m_cs};

    always @(negedge clk) chk("cycle_outputs", 64'(dut_vec), 64'(exp_vec));

    typedef struct {int cyc; logic [7:0] a; logic [11:0] d;} wr_t;
    wr_t wlog[$];
    always @(negedge clk) if (pmem_le === 1'b1) wlog.push_back('{cyc_no, pmem_laddr, pmem_ldata});

    task automatic cyc(input logic s, input logic a, input logic v, input logic [11:0] d);
        @(negedge clk);
        start = s; abort = a; in_valid = v; in_data = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 12'h000);
    endtask

    task automatic chk_log(input string name, input int n, input logic [11:0] d0, input logic [11:0] dl);
        chk({name, "_writes"}, 64'(wlog.size()), 64'(n));
        for (int i = 0; i < wlog.size(); i++) chk({name, "_addr"}, 64'(wlog[i].a), 64'(i));
        if (wlog.size() > 0) begin
            chk({name, "_first_data"}, 64'(wlog[0].d), 64'(d0));
            chk({name, "_last_data"}, 64'(wlog[wlog.size()-1].d), 64'(dl));
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 0; abort = 0; in_valid = 0; in_data = '0;
        repeat (2) @(negedge clk);
        chk("reset_vector", 64'(dut_vec), 64'({1'b0, 1'b0, 8'h00, 12'h000, 1'b0, 1'b1, 1'b0, 9'd0, 12'h000}));
        rst_n = 1'b1;
        idle(2);

        // normal back-to-back load
        wlog.delete();
        cyc(1, 0, 0, 12'h000);
        cyc(0, 0, 1, 12'h101); cyc(0, 0, 1, 12'h202); cyc(0, 0, 1, 12'h000);
        idle(1);
        chk("normal_done", 64'(load_done), 64'd1);
        chk("normal_hold", 64'(core_hold), 64'd0);
        chk("normal_le_first_done", 64'(pmem_le), 64'd1);
        chk("normal_count", 64'(word_count), 64'd3);
        chk("normal_csum", 64'(checksum), 64'h303);
        idle(2);
        chk_log("normal", 3, 12'h101, 12'h000);
        if (wlog.size() == 3) chk("normal_no_bubble", 64'(wlog[2].cyc - wlog[0].cyc), 64'd2);

        // stalled source: valid 1,0,0,1,1
        wlog.delete();
        cyc(1, 0, 0, 12'h000);
        cyc(0, 0, 1, 12'hA5A); cyc(0, 0, 0, 12'hFFF); idle(1);
        cyc(0, 0, 1, 12'h0B0); cyc(0, 0, 1, 12'h000);
        idle(3);
        chk_log("stall", 3, 12'hA5A, 12'h000);
        chk("stall_csum", 64'(checksum), 64'hAEA);

        // overflow at MAX_WORDS
        wlog.delete();
        cyc(1, 0, 0, 12'h000);
        cyc(0, 0, 1, 12'h001); cyc(0, 0, 1, 12'h002); cyc(0, 0, 1, 12'h003); cyc(0, 0, 1, 12'h004);
        cyc(0, 0, 1, 12'h005);
        chk("ovf_error", 64'(error), 64'd1);
        chk("ovf_ready", 64'(in_ready), 64'd0);
        chk("ovf_hold", 64'(core_hold), 64'd1);
        idle(3);
        chk_log("ovf", 4, 12'h001, 12'h004);
        chk("ovf_count_held", 64'(word_count), 64'd4);

        // terminator in the last slot
        wlog.delete();
        cyc(1, 0, 0, 12'h000);
        cyc(0, 0, 1, 12'h001); cyc(0, 0, 1, 12'h002); cyc(0, 0, 1, 12'h003); cyc(0, 0, 1, 12'h000);
        idle(1);
        chk("last_done", 64'(load_done), 64'd1);
        chk("last_error", 64'(error), 64'd0);
        idle(2);
        chk_log("last", 4, 12'h001, 12'h000);

        // abort with the 2nd word; start ignored in LOAD; then restart
        wlog.delete();
        cyc(1, 0, 0, 12'h000);
        cyc(0, 0, 1, 12'h111);
        cyc(1, 0, 0, 12'h000);
        cyc(1, 1, 1, 12'h222);
        idle(2);
        chk("abort_ready", 64'(in_ready), 64'd0);
        chk("abort_count", 64'(word_count), 64'd1);
        chk_log("abort", 1, 12'h111, 12'h111);
        wlog.delete();
        cyc(1, 1, 0, 12'h000);
        idle(1);
        chk("restart_count", 64'(word_count), 64'd0);
        chk("restart_ready", 64'(in_ready), 64'd1);
        cyc(0, 0, 1, 12'h333); cyc(0, 0, 1, 12'h000);
        idle(2);
        chk_log("restart", 2, 12'h333, 12'h000);

        // asynchronous reset mid-load with a write pending
        cyc(1, 0, 0, 12'h000);
        cyc(0, 0, 1, 12'h0AA); cyc(0, 0, 1, 12'h0BB);
        @(posedge clk);
        #2 rst_n = 1'b0;
        start = 0; abort = 0; in_valid = 0; in_data = '0;
        #1 chk("async_reset_vector", 64'(dut_vec),
               64'({1'b0, 1'b0, 8'h00, 12'h000, 1'b0, 1'b1, 1'b0, 9'd0, 12'h000}));
        idle(2);
        rst_n = 1'b1;
        cyc(0, 0, 1, 12'h0CC);
        idle(2);
        chk("post_reset_idle", 64'(in_ready), 64'd0);
        chk("post_reset_count", 64'(word_count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
